// File: rtl/result_serializer_pkg.sv
// result_serializer_pkg: shared constants, state encodings and index helper
// for the result serializer (bank size, packet width, nibble count).
package result_serializer_pkg;

  localparam int NUM_ENCRYPTERS       = 4;
  localparam int ENCRYPTER_WIDTH      = 16;
  localparam int ENCRYPTER_QSPI_COUNT = ENCRYPTER_WIDTH / 4;
  localparam int ENC_IDX_W            = $clog2(NUM_ENCRYPTERS);
  localparam int NIB_IDX_W            = $clog2(ENCRYPTER_QSPI_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_CHECK = 2'd2
  } ser_state_e;

  // Round-robin successor, wrapping the last encrypter back to 0.
  function automatic logic [ENC_IDX_W-1:0] next_enc_idx(input logic [ENC_IDX_W-1:0] idx);
    if (idx == ENC_IDX_W'(NUM_ENCRYPTERS - 1)) begin
      return '0;
    end
    return idx + ENC_IDX_W'(1);
  endfunction

endpackage

// File: rtl/result_serializer_if.sv
// result_serializer_if: encrypter-bank result bus plus outbound QSPI nibble
// bus. The serializer uses the slave view; the bank/transmitter side uses master.
interface result_serializer_if;
  import result_serializer_pkg::*;

  logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0] encrypters_result;
  logic [NUM_ENCRYPTERS-1:0]                      encrypters_result_valid;
  logic [NUM_ENCRYPTERS-1:0]                      encrypters_result_ack;
  logic [3:0]                                     qspi_data;
  logic                                           qspi_sending;
  logic                                           qspi_ready;

  modport slave (
    input  encrypters_result, encrypters_result_valid, qspi_ready,
    output encrypters_result_ack, qspi_data, qspi_sending
  );

  modport master (
    output encrypters_result, encrypters_result_valid, qspi_ready,
    input  encrypters_result_ack, qspi_data, qspi_sending
  );

endinterface

// File: rtl/result_serializer_nibble_shift_reg.sv
// result_serializer_nibble_shift_reg: parallel-load register that shifts one
// nibble right per enable. With CHK_EN set, the final data shift drops the
// running XOR of all shifted nibbles into the low nibble so the check nibble
// is presented straight from the register.
module result_serializer_nibble_shift_reg #(
  parameter int DATA_W = 16,
  parameter bit CHK_EN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              shift_i,
  input  logic              last_i,
  output logic [3:0]        nibble_o
);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        xor_q, xor_d;

  // Next-state: load wins over shift; XOR accumulates every nibble shifted out.
  always_comb begin
    shift_d = shift_q;
    xor_d   = xor_q;
    if (load_i) begin
      shift_d = data_i;
      xor_d   = '0;
    end else if (shift_i) begin
      xor_d = xor_q ^ shift_q[3:0];
      if (CHK_EN && last_i) begin
        shift_d = {{(DATA_W-4){1'b0}}, xor_d};
      end else begin
        shift_d = shift_q >> 4;
      end
    end
  end

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      xor_q   <= '0;
    end else begin
      shift_q <= shift_d;
      xor_q   <= xor_d;
    end
  end

  assign nibble_o = shift_q[3:0];

endmodule

// File: rtl/result_serializer.sv
// result_serializer: drains ciphertext packets from the encrypter bank in
// strict round-robin order and shifts each one out on the QSPI nibble bus,
// least-significant nibble first.
// Optional feature: define RESULT_SERIALIZER_CHECK_EN to append an XOR check
// nibble after each packet (adds the CHECK state, removes gapless reload).
module result_serializer
  import result_serializer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  result_serializer_if.slave   bus,
  output logic [1:0]           state_out,
  output logic [ENC_IDX_W-1:0] encrypter_index_out,
  output logic [NIB_IDX_W-1:0] nibble_index_out
);

`ifdef RESULT_SERIALIZER_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  ser_state_e                state_q;
  logic [ENC_IDX_W-1:0]      idx_q;
  logic [NIB_IDX_W-1:0]      nib_q;
  logic                      sending_q;

  logic                      last_nib;
  logic                      accept;
  logic                      pkt_end;
  logic                      boundary;
  logic                      restart_take;
  logic                      capture;
  logic [NUM_ENCRYPTERS-1:0] ack;
  logic [3:0]                nibble;

  // Packet-boundary decode: restart and capture are only legal at a boundary,
  // and restart takes priority over a capture in the same cycle.
  always_comb begin
    last_nib = (nib_q == NIB_IDX_W'(ENCRYPTER_QSPI_COUNT - 1));
    accept   = sending_q && bus.qspi_ready;
`ifdef RESULT_SERIALIZER_CHECK_EN
    pkt_end  = (state_q == ST_CHECK) && bus.qspi_ready;
`else
    pkt_end  = (state_q == ST_SEND) && bus.qspi_ready && last_nib;
`endif
    boundary     = (state_q == ST_IDLE) || pkt_end;
    restart_take = restart && boundary;
    capture      = !reset && boundary && !restart_take &&
                   bus.encrypters_result_valid[idx_q];
  end

  // Acknowledge only the encrypter whose packet is being captured this cycle.
  always_comb begin
    ack = '0;
    if (capture) begin
      ack[idx_q] = 1'b1;
    end
  end

  // Serializer FSM with registered sending flag and indices.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      nib_q     <= '0;
      sending_q <= 1'b0;
    end else begin
      if (restart_take) begin
        idx_q <= '0;
      end
      if (capture) begin
        state_q   <= ST_SEND;
        sending_q <= 1'b1;
        idx_q     <= next_enc_idx(idx_q);
        nib_q     <= '0;
      end else begin
        case (state_q)
          ST_SEND: begin
            if (bus.qspi_ready) begin
              nib_q <= nib_q + NIB_IDX_W'(1);
              if (last_nib) begin
`ifdef RESULT_SERIALIZER_CHECK_EN
                state_q   <= ST_CHECK;
`else
                state_q   <= ST_IDLE;
                sending_q <= 1'b0;
`endif
              end
            end
          end
`ifdef RESULT_SERIALIZER_CHECK_EN
          ST_CHECK: begin
            if (bus.qspi_ready) begin
              state_q   <= ST_IDLE;
              sending_q <= 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  result_serializer_nibble_shift_reg #(
    .DATA_W (ENCRYPTER_WIDTH),
    .CHK_EN (CHK_EN)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load_i   (capture),
    .data_i   (bus.encrypters_result[idx_q]),
    .shift_i  (accept),
    .last_i   ((state_q == ST_SEND) && last_nib),
    .nibble_o (nibble)
  );

  assign bus.encrypters_result_ack = ack;
  assign bus.qspi_data             = nibble;
  assign bus.qspi_sending          = sending_q;
  assign state_out                 = state_q;
  assign encrypter_index_out       = idx_q;
  assign nibble_index_out          = nib_q;

endmodule
